// File: rtl/pio_pkg.sv
// pio_pkg: shared constants for the bidirectional edge-capturing PIO.
// Holds the Avalon register word addresses and the encodings of the
// EDGE_TYPE parameter used by the top level and the edge-detect sub-module.
package pio_pkg;

  // Register word addresses on the Avalon slave
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  // EDGE_TYPE encodings
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_bidir_edge_if.sv
// pio_bidir_edge_if: Avalon-MM slave bus bundle for pio_bidir_edge.
// Signals:
//   address    word address (3 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   readdata   32-bit registered read data (driven by the slave)
interface pio_bidir_edge_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync_edge.sv
// pio_sync_edge: input side of the PIO.
// Synchronises the asynchronous pad inputs, keeps a one-cycle delayed copy,
// and reports edges of the selected type once the post-reset arming counter
// has saturated.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   pio_in    raw pad inputs (asynchronous)
//   sync_in   synchronised pad value
//   edge_det  one-cycle pulse per bit on a detected edge
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = EDGE_ANY,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);

  // Arming completes once the synchroniser and prev_in have both been
  // loaded from real pad values since reset.
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_in;
  logic [2:0]                        arm_cnt;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;
  logic [WIDTH-1:0]                  sel_edge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_in <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pio_in};
      prev_in <= sync_q[SYNC_STAGES-1];
      if (arm_cnt != ARM_MAX)
        arm_cnt <= arm_cnt + 3'd1;
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_in;
  assign fall    = ~sync_in & prev_in;

  always_comb begin
    sel_edge = rise | fall;
    if (EDGE_TYPE == EDGE_RISE)
      sel_edge = rise;
    else if (EDGE_TYPE == EDGE_FALL)
      sel_edge = fall;
  end

  // Suppress the 0->pad transition seen right after reset so lines that
  // idle high never report a spurious edge.
  assign edge_det = (arm_cnt == ARM_MAX) ? sel_edge : '0;

endmodule

// File: rtl/pio_bidir_edge.sv
// pio_bidir_edge: WIDTH-bit Avalon-MM GPIO with per-bit direction, optional
// open-drain drive, synchronised readback, atomic set/clear, edge capture
// and a maskable level interrupt.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   bus      Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   irq      registered level interrupt = |(edge_cap & irq_mask)
//   pio_in   raw pad inputs
//   pio_out  pad output values
//   pio_oe   pad output enables, 1 = drive
module pio_bidir_edge
  import pio_pkg::*;
#(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_ANY,
  parameter bit          OPEN_DRAIN  = 1'b0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  pio_bidir_edge_if.slave   bus,
  output logic              irq,
  input  logic [WIDTH-1:0]  pio_in,
  output logic [WIDTH-1:0]  pio_out,
  output logic [WIDTH-1:0]  pio_oe
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_vec;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] cap_clr;
  logic [31:0]      rd_word;
  logic             wr;

  assign wd = bus.writedata[WIDTH-1:0];
  assign wr = bus.chipselect && !bus.write_n;

  // Bits of writedata above WIDTH have no register behind them.
  if (WIDTH < 32) begin : g_wd_high
    logic unused_wd_high;
    assign unused_wd_high = ^bus.writedata[31:WIDTH];
  end

  pio_sync_edge #(
    .WIDTH       (WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .reset    (reset),
    .pio_in   (pio_in),
    .sync_in  (sync_in),
    .edge_det (edge_vec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= RESET_VALUE[WIDTH-1:0];
      dir      <= '0;
      irq_mask <= '0;
    end else if (wr) begin
      case (bus.address)
        ADDR_DATA:    data_out <= wd;
        ADDR_DIR:     dir      <= wd;
        ADDR_IRQMASK: irq_mask <= wd;
        ADDR_OUTSET:  data_out <= data_out | wd;
        ADDR_OUTCLR:  data_out <= data_out & ~wd;
        default:      ;
      endcase
    end
  end

  // The clear is applied before OR-ing in new edges so an edge arriving in
  // the same cycle as its W1C keeps the bit set.
  assign cap_clr = (wr && bus.address == ADDR_EDGECAP) ? wd : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_vec;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  always_comb begin
    rd_word = '0;
    case (bus.address)
      ADDR_DATA:    rd_word[WIDTH-1:0] = sync_in;
      ADDR_DIR:     rd_word[WIDTH-1:0] = dir;
      ADDR_IRQMASK: rd_word[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_word[WIDTH-1:0] = edge_cap;
      default:      rd_word = '0;
    endcase
  end

  // Read data is registered every cycle regardless of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bus.readdata <= '0;
    else
      bus.readdata <= rd_word;
  end

  // Open-drain: only ever drive low; a 1 in data_out releases the line.
  if (OPEN_DRAIN) begin : g_od
    assign pio_out = '0;
    assign pio_oe  = dir & ~data_out;
  end else begin : g_pp
    assign pio_out = data_out;
    assign pio_oe  = dir;
  end

endmodule

// File: tb/tb_pio_bidir_edge.sv
// tb_pio_bidir_edge: directed self-checking bench for pio_bidir_edge.
// dut_a: WIDTH=8, rising-edge capture, push-pull.
// dut_b: WIDTH=2, any-edge capture, open-drain with a pull-up wire loopback.
module tb_pio_bidir_edge;

  import pio_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] pio_in_a;
  logic [7:0] pio_out_a;
  logic [7:0] pio_oe_a;
  logic       irq_a;
  logic [1:0] pio_in_b;
  logic [1:0] pio_out_b;
  logic [1:0] pio_oe_b;
  logic       irq_b;

  int errors;
  int checks;

  pio_bidir_edge_if bus_a ();
  pio_bidir_edge_if bus_b ();

  pio_bidir_edge #(
    .WIDTH       (8),
    .RESET_VALUE (32'h0),
    .EDGE_TYPE   (EDGE_RISE),
    .OPEN_DRAIN  (1'b0),
    .SYNC_STAGES (2)
  ) dut_a (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_a),
    .irq     (irq_a),
    .pio_in  (pio_in_a),
    .pio_out (pio_out_a),
    .pio_oe  (pio_oe_a)
  );

  pio_bidir_edge #(
    .WIDTH       (2),
    .RESET_VALUE (32'h0),
    .EDGE_TYPE   (EDGE_ANY),
    .OPEN_DRAIN  (1'b1),
    .SYNC_STAGES (2)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_b),
    .irq     (irq_b),
    .pio_in  (pio_in_b),
    .pio_out (pio_out_b),
    .pio_oe  (pio_oe_b)
  );

  // Pull-up wire: a bit is low only where the pad actively drives a 0.
  assign pio_in_b = ~(pio_oe_b & ~pio_out_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic idleBus();
    bus_a.chipselect = 1'b0;
    bus_a.write_n    = 1'b1;
    bus_b.chipselect = 1'b0;
    bus_b.write_n    = 1'b1;
  endtask

  task automatic writeReg(input bit sel_b, input logic [2:0] addr,
                          input logic [31:0] data);
    @(negedge clk);
    if (sel_b) begin
      bus_b.address    = addr;
      bus_b.writedata  = data;
      bus_b.chipselect = 1'b1;
      bus_b.write_n    = 1'b0;
    end else begin
      bus_a.address    = addr;
      bus_a.writedata  = data;
      bus_a.chipselect = 1'b1;
      bus_a.write_n    = 1'b0;
    end
    @(posedge clk);
    #1;
    idleBus();
  endtask

  task automatic readReg(input bit sel_b, input logic [2:0] addr,
                         output logic [31:0] data);
    @(negedge clk);
    if (sel_b) begin
      bus_b.address    = addr;
      bus_b.chipselect = 1'b1;
      bus_b.write_n    = 1'b1;
    end else begin
      bus_a.address    = addr;
      bus_a.chipselect = 1'b1;
      bus_a.write_n    = 1'b1;
    end
    @(posedge clk);
    #1;
    data = sel_b ? bus_b.readdata : bus_a.readdata;
    idleBus();
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    @(negedge clk);
    pio_in_a = value;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [7:0] pin_value);
    @(negedge clk);
    reset    = 1'b1;
    pio_in_a = pin_value;
    waitCycles(3);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    errors           = 0;
    checks           = 0;
    reset            = 1'b1;
    pio_in_a         = 8'h00;
    bus_a.address    = 3'd0;
    bus_a.writedata  = 32'h0;
    bus_b.address    = 3'd0;
    bus_b.writedata  = 32'h0;
    idleBus();

    // Reset state with pins low
    doReset(8'h00);
    checkOutput("rst_irq",    {31'h0, irq_a}, 32'h0);
    checkOutput("rst_oe",     {24'h0, pio_oe_a}, 32'h0);
    checkOutput("rst_out",    {24'h0, pio_out_a}, 32'h0);
    readReg(1'b0, ADDR_DIR, rd);     checkOutput("rst_dir", rd, 32'h0);
    readReg(1'b0, ADDR_DATA, rd);    checkOutput("rst_data", rd, 32'h0);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("rst_edgecap", rd, 32'h0);

    // Reset with pins idling high: arming must hide the startup rise
    doReset(8'hFF);
    waitCycles(6);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("arm_edgecap", rd, 32'h0);
    readReg(1'b0, ADDR_DATA, rd);    checkOutput("arm_data", rd, 32'hFF);
    checkOutput("arm_irq", {31'h0, irq_a}, 32'h0);
    applyStimulus(8'h00);
    waitCycles(5);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("fall_ignored", rd, 32'h0);

    // Output path: DATA, DIR, OUTSET, OUTCLR
    writeReg(1'b0, ADDR_DATA, 32'hFFFF_FFA5);
    checkOutput("out_data", {24'h0, pio_out_a}, 32'hA5);
    writeReg(1'b0, ADDR_DIR, 32'h0000_00FF);
    checkOutput("oe_dir", {24'h0, pio_oe_a}, 32'hFF);
    writeReg(1'b0, ADDR_OUTSET, 32'h02);
    checkOutput("out_set", {24'h0, pio_out_a}, 32'hA7);
    writeReg(1'b0, ADDR_OUTCLR, 32'h80);
    checkOutput("out_clr", {24'h0, pio_out_a}, 32'h27);
    readReg(1'b0, ADDR_DIR, rd);    checkOutput("rd_dir", rd, 32'hFF);
    readReg(1'b0, ADDR_OUTSET, rd); checkOutput("rd_outset", rd, 32'h0);
    readReg(1'b0, 3'd7, rd);        checkOutput("rd_addr7", rd, 32'h0);

    // Rising edge on bit 2 with mask set: capture, irq, W1C
    writeReg(1'b0, ADDR_IRQMASK, 32'h04);
    readReg(1'b0, ADDR_IRQMASK, rd); checkOutput("rd_mask", rd, 32'h04);
    applyStimulus(8'h04);
    waitCycles(3);
    checkOutput("irq_not_yet", {31'h0, irq_a}, 32'h0);
    waitCycles(1);
    checkOutput("irq_set", {31'h0, irq_a}, 32'h1);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("cap_bit2", rd, 32'h04);
    writeReg(1'b0, ADDR_EDGECAP, 32'h04);
    waitCycles(1);
    checkOutput("irq_clr", {31'h0, irq_a}, 32'h0);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("cap_cleared", rd, 32'h0);

    // W1C landing on the same cycle as a new edge on bit 0: set wins
    applyStimulus(8'h05);
    @(posedge clk);
    @(posedge clk);
    writeReg(1'b0, ADDR_EDGECAP, 32'h01);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("set_wins", rd, 32'h01);
    waitCycles(2);
    checkOutput("masked_irq", {31'h0, irq_a}, 32'h0);
    writeReg(1'b0, ADDR_EDGECAP, 32'h01);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("cap0_cleared", rd, 32'h0);

    // Open-drain instance with pull-up loopback
    writeReg(1'b1, ADDR_DATA, 32'h01);
    writeReg(1'b1, ADDR_DIR, 32'h03);
    checkOutput("od_oe",  {30'h0, pio_oe_b}, 32'h2);
    checkOutput("od_out", {30'h0, pio_out_b}, 32'h0);
    waitCycles(4);
    readReg(1'b1, ADDR_DATA, rd);    checkOutput("od_wire", rd, 32'h01);
    readReg(1'b1, ADDR_EDGECAP, rd); checkOutput("od_fall_cap", rd, 32'h02);
    checkOutput("od_irq_masked", {31'h0, irq_b}, 32'h0);
    writeReg(1'b1, ADDR_IRQMASK, 32'h02);
    waitCycles(1);
    checkOutput("od_irq", {31'h0, irq_b}, 32'h1);
    writeReg(1'b1, ADDR_DATA, 32'h03);
    checkOutput("od_release_oe", {30'h0, pio_oe_b}, 32'h0);
    waitCycles(4);
    readReg(1'b1, ADDR_DATA, rd);    checkOutput("od_released", rd, 32'h03);

    // Asynchronous reset in the middle of activity
    writeReg(1'b0, ADDR_DATA, 32'hFF);
    applyStimulus(8'h01);
    waitCycles(4);
    applyStimulus(8'h05);
    waitCycles(5);
    checkOutput("pre_rst_irq", {31'h0, irq_a}, 32'h1);
    checkOutput("pre_rst_out", {24'h0, pio_out_a}, 32'hFF);
    #2;
    reset    = 1'b1;
    pio_in_a = 8'h00;
    #1;
    checkOutput("async_out", {24'h0, pio_out_a}, 32'h0);
    checkOutput("async_oe",  {24'h0, pio_oe_a}, 32'h0);
    checkOutput("async_irq", {31'h0, irq_a}, 32'h0);
    checkOutput("async_irq_b", {31'h0, irq_b}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    readReg(1'b0, ADDR_DIR, rd);     checkOutput("post_dir", rd, 32'h0);
    readReg(1'b0, ADDR_IRQMASK, rd); checkOutput("post_mask", rd, 32'h0);
    readReg(1'b0, ADDR_EDGECAP, rd); checkOutput("post_edgecap", rd, 32'h0);
    readReg(1'b0, ADDR_DATA, rd);    checkOutput("post_data", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_bidir_edge.md
Name: pio_bidir_edge

Overview:
- Parametrised Avalon-MM general-purpose I/O port, WIDTH bits wide. Successor to the single-bit output PIOs that bit-bang the power-monitor I2C lines.
- Adds per-bit direction control, an optional open-drain mode for I2C SCL/SDA, and synchronised input readback.
- Adds atomic bit set/clear registers, edge capture and a maskable level interrupt.
- Sits in the Qsys fabric between the HPS/Nios bus and board pins.

Parameters:
- WIDTH, 8, number of I/O bits (1..32).
- RESET_VALUE, 0, reset value of data_out[WIDTH-1:0].
- EDGE_TYPE, 2, edges captured: 0 rising, 1 falling, 2 any.
- OPEN_DRAIN, 0, 1 = pins are only ever driven low (I2C style).
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  3  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  registered read data; bits above WIDTH read 0
- irq  out  1  level interrupt request
- pio_in  in  WIDTH  raw pad inputs (asynchronous)
- pio_out  out  WIDTH  pad output values
- pio_oe  out  WIDTH  pad output enables, 1 = drive

Behaviour:
- Reset is asynchronous and active-high; all flops are clocked by clk. Reset values:
  - data_out = RESET_VALUE; dir = 0 (all inputs); irq_mask = 0; edge_cap = 0.
  - sync chain = 0; readdata = 0; irq = 0; arm_cnt = 0.
- Write occurs when chipselect && !write_n. Register map:
  - 0 DATA: W sets data_out. R returns synchronised pin value sync_in.
  - 1 DIR: R/W, 1 = output.
  - 2 IRQMASK: R/W.
  - 3 EDGECAP: R returns edge_cap. W1C: each 1 in writedata clears that bit.
  - 4 OUTSET: W data_out |= wd. R returns 0.
  - 5 OUTCLR: W data_out &= ~wd. R returns 0.
  - 6, 7: R return 0; W ignored.
- Read latency is fixed at 1 cycle. readdata is registered from address every cycle, independent of chipselect.
- Pin drive:
  - OPEN_DRAIN=0: pio_out = data_out; pio_oe = dir.
  - OPEN_DRAIN=1: pio_out = 0; pio_oe = dir & ~data_out. A 1 releases the line.
  - Both are combinational from registers, so a write is visible on pins the cycle after the write.
- Input path:
  - pio_in passes through SYNC_STAGES flops to give sync_in; prev_in holds sync_in delayed by one cycle.
  - Rising edge = sync_in & ~prev_in. Falling edge = ~sync_in & prev_in. Any = their OR.
- Post-reset arming:
  - arm_cnt counts from 0 to SYNC_STAGES+1 and then saturates.
  - Edge detection is suppressed until saturation, so lines idling high do not raise spurious edges.
- Edge capture:
  - edge_cap[i] sets on a detected edge and holds until cleared.
  - A W1C on the same cycle as a new edge on that bit leaves the bit set (set wins).
- irq = |(edge_cap & irq_mask), registered. Asserts 1 cycle after the capture bit sets; deasserts 1 cycle after clear or mask.
- Edge capture applies to all bits regardless of dir.
- In open-drain mode the readback on DATA reflects the actual wire level, enabling clock-stretch detection.
- Reset asserted mid-operation returns every register to its reset value immediately, regardless of clk.

Decomposition:
- Shared package pio_pkg holds:
  - register address constants ADDR_DATA..ADDR_OUTCLR;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings.
- One sub-module, pio_sync_edge: the per-port synchroniser, prev_in register, arming counter and edge detect. Its output is an edge vector plus sync_in.
- Register file, read mux and irq logic live in the top module.

Test Plan:
- Reset, then read DIR, DATA, EDGECAP with pio_in=0 -> all return 0, irq=0, pio_oe=0. Repeat with pio_in=all 1s -> no edge captured (arming works).
- WIDTH=8: write DATA=0xA5, DIR=0xFF, then OUTSET 0x02, then OUTCLR 0x80 -> pio_out = 0xA5, 0xA7, 0x27 on successive post-write cycles; pio_oe=0xFF.
- OPEN_DRAIN=1, DIR=0x03, DATA=0x01 -> pio_oe=0x02, pio_out=0x00. Model the wire as the pull-up OR'd with drive-low and loop it back on pio_in -> DATA reads 0x01 after SYNC_STAGES+1 cycles.
- EDGE_TYPE=0, IRQMASK=0x04, raise pio_in[2] -> edge_cap=0x04 after SYNC_STAGES+1 cycles, irq high one cycle later. Write EDGECAP=0x04 -> irq low the next cycle.
- W1C EDGECAP=0x01 on the same cycle that a new edge on bit 0 is detected -> edge_cap[0] remains 1. An edge on a masked bit sets edge_cap but irq stays 0.
- Assert reset mid-stream with DATA=0xFF and irq high -> pio_out, pio_oe and irq go to 0 asynchronously. After release, reads match the reset values.
